// File: rtl/terpine_pkg.sv
// Shared definitions for the RMII receive path: CRC-32 constants, dibit codes,
// the deframer state enum and the per-dibit state-update helper.
package terpine_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  localparam logic [1:0]  SFD_DIBIT     = 2'b11;
  localparam logic [1:0]  PRE_DIBIT     = 2'b01;
  localparam logic [1:0]  NULL_DIBIT    = 2'b00;

  // Frame length counter stops here; a frame that reaches it is never good.
  localparam logic [10:0] LEN_SAT       = 11'd2047;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_PREAMBLE = 2'd1,
    RX_DATA     = 2'd2,
    RX_DROP     = 2'd3
  } rx_state_t;

  // Everything the deframer carries from one dibit to the next.
  typedef struct packed {
    rx_state_t   state;
    logic [7:0]  shift;
    logic [1:0]  cnt;
    logic [10:0] len;
    logic [31:0] crc;
  } rx_ctx_t;

  // Context after one dibit plus the events that dibit produced.
  typedef struct packed {
    rx_ctx_t ctx;
    logic    byteDone;
    logic    frameEnd;
  } rx_step_t;

  localparam rx_ctx_t CTX_RESET = '{
    state: RX_IDLE,
    shift: 8'h00,
    cnt:   2'd0,
    len:   11'd0,
    crc:   CRC32_INIT
  };

  // Advance the deframer by exactly one dibit. The CRC value already stepped
  // over this dibit is supplied by the caller so the CRC datapath stays in its
  // own module and can be chained for the two dibits of a clock.
  function automatic rx_step_t rxDibitStep(
    input rx_ctx_t     cur,
    input logic [1:0]  dibit,
    input logic        dv,
    input logic [31:0] crcStepped
  );
    rx_step_t res;
    res.ctx      = cur;
    res.byteDone = 1'b0;
    res.frameEnd = 1'b0;
    case (cur.state)
      RX_IDLE: begin
        if (dv && (dibit != NULL_DIBIT)) begin
          res.ctx.state = (dibit == PRE_DIBIT) ? RX_PREAMBLE : RX_DROP;
        end
      end
      RX_PREAMBLE: begin
        if (!dv) begin
          res.ctx.state = RX_IDLE;
        end else if (dibit == SFD_DIBIT) begin
          res.ctx.state = RX_DATA;
          res.ctx.shift = 8'h00;
          res.ctx.cnt   = 2'd0;
          res.ctx.len   = 11'd0;
          res.ctx.crc   = CRC32_INIT;
        end else if (dibit != PRE_DIBIT) begin
          res.ctx.state = RX_DROP;
        end
      end
      RX_DATA: begin
        if (!dv) begin
          // Counters and CRC are left untouched so the verdict can be judged.
          res.ctx.state = RX_IDLE;
          res.frameEnd  = 1'b1;
        end else begin
          res.ctx.shift = {dibit, cur.shift[7:2]};
          res.ctx.crc   = crcStepped;
          res.ctx.cnt   = cur.cnt + 2'd1;
          if (cur.cnt == 2'd3) begin
            res.byteDone = 1'b1;
            if (cur.len != LEN_SAT) begin
              res.ctx.len = cur.len + 11'd1;
            end
          end
        end
      end
      RX_DROP: begin
        if (!dv) begin
          res.ctx.state = RX_IDLE;
        end
      end
      default: begin
        res.ctx.state = RX_IDLE;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rmii_rx_deframer_crc32.sv
// Combinational CRC-32 step over one dibit, reflected polynomial, bit 0 of
// the dibit entering the register first.
module crc32_dibit
  import terpine_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [1:0]  i_dibit,
  output logic [31:0] o_crc
);

  logic [31:0] w_afterBit0;

  // Two serial shift-and-xor steps, earlier bit first.
  always_comb begin
    w_afterBit0 = {1'b0, i_crc[31:1]}
                ^ (((i_crc[0] ^ i_dibit[0]) == 1'b1) ? CRC32_POLY : 32'h0);
    o_crc       = {1'b0, w_afterBit0[31:1]}
                ^ (((w_afterBit0[0] ^ i_dibit[1]) == 1'b1) ? CRC32_POLY : 32'h0);
  end

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD from a two-dibit-per-clock
// stream, rebuilds LSB-first bytes, checks CRC-32 and length, and reports
// each frame with byte/first/end strobes and a good/bad verdict.
module rmii_rx_deframer
  import terpine_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        mii_clk,
  input  logic        mii_rst_n,
  input  logic [3:0]  rmii_D,
  input  logic [1:0]  rmii_DV,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        rx_first,
  output logic        rx_end,
  output logic        rx_good,
  output logic [10:0] rx_len
);

  localparam logic [31:0] C_MIN_LEN = 32'(MIN_LEN);
  localparam logic [31:0] C_MAX_LEN = 32'(MAX_LEN);

  rx_ctx_t     r_ctx;
  rx_step_t    w_step0;
  rx_step_t    w_step1;
  logic [31:0] w_crc0;
  logic [31:0] w_crc1;

  logic        w_byteDone;
  logic [7:0]  w_byte;
  logic        w_first;
  logic        w_frameEnd;
  logic        w_good;
  logic        w_endNow;

  logic [7:0]  w_nxtByte;
  logic        w_nxtValid;
  logic        w_nxtFirst;
  logic        w_nxtEnd;
  logic        w_nxtGood;
  logic [10:0] w_nxtLen;
  logic        w_nxtPending;
  logic        w_nxtPendGood;
  logic [10:0] w_nxtPendLen;

  logic [7:0]  r_rxByte;
  logic        r_rxValid;
  logic        r_rxFirst;
  logic        r_rxEnd;
  logic        r_rxGood;
  logic [10:0] r_rxLen;
  logic        r_endPending;
  logic        r_pendGood;
  logic [10:0] r_pendLen;

  // The later dibit's CRC starts from whatever the earlier dibit left behind,
  // which covers an SFD preset landing on the earlier half.
  crc32_dibit u_crcEarly (
    .i_crc   (r_ctx.crc),
    .i_dibit (rmii_D[1:0]),
    .o_crc   (w_crc0)
  );

  crc32_dibit u_crcLate (
    .i_crc   (w_step0.ctx.crc),
    .i_dibit (rmii_D[3:2]),
    .o_crc   (w_crc1)
  );

  // State register: context after both dibits of the cycle.
  always_ff @(posedge mii_clk or negedge mii_rst_n) begin
    if (!mii_rst_n) begin
      r_ctx <= CTX_RESET;
    end else begin
      r_ctx <= w_step1.ctx;
    end
  end

  // Next state for the earlier dibit.
  always_comb begin
    w_step0 = rxDibitStep(r_ctx, rmii_D[1:0], rmii_DV[0], w_crc0);
  end

  // Next state for the later dibit, continuing from the earlier one.
  always_comb begin
    w_step1 = rxDibitStep(w_step0.ctx, rmii_D[3:2], rmii_DV[1], w_crc1);
  end

  // Output decode. Once a frame ends nothing can touch the counters or CRC
  // within the same cycle, so the verdict is always read from the final
  // context. An end that shares its cycle with a completed byte is held back
  // one clock so rx_end never overlaps rx_valid.
  always_comb begin
    w_byteDone = w_step0.byteDone | w_step1.byteDone;
    w_byte     = w_step0.byteDone ? w_step0.ctx.shift : w_step1.ctx.shift;
    w_first    = w_step0.byteDone ? (w_step0.ctx.len == 11'd1)
                                  : (w_step1.ctx.len == 11'd1);
    w_frameEnd = w_step0.frameEnd | w_step1.frameEnd;
    w_good     = (w_step1.ctx.cnt == 2'd0)
              && (w_step1.ctx.crc == CRC32_RESIDUE)
              && (w_step1.ctx.len != LEN_SAT)
              && ({21'd0, w_step1.ctx.len} >= C_MIN_LEN)
              && ({21'd0, w_step1.ctx.len} <= C_MAX_LEN);
    w_endNow   = w_frameEnd & ~w_byteDone;

    w_nxtValid = w_byteDone;
    w_nxtByte  = w_byteDone ? w_byte : r_rxByte;
    w_nxtFirst = w_byteDone & w_first;
    w_nxtEnd   = r_endPending | w_endNow;
    w_nxtGood  = r_endPending ? r_pendGood : (w_endNow & w_good);
    w_nxtLen   = r_endPending ? r_pendLen
               : (w_endNow ? w_step1.ctx.len : r_rxLen);

    w_nxtPending  = w_frameEnd & w_byteDone;
    w_nxtPendGood = w_nxtPending ? w_good : r_pendGood;
    w_nxtPendLen  = w_nxtPending ? w_step1.ctx.len : r_pendLen;
  end

  // Registered outputs and the deferred end-of-frame holding stage.
  always_ff @(posedge mii_clk or negedge mii_rst_n) begin
    if (!mii_rst_n) begin
      r_rxByte     <= 8'h00;
      r_rxValid    <= 1'b0;
      r_rxFirst    <= 1'b0;
      r_rxEnd      <= 1'b0;
      r_rxGood     <= 1'b0;
      r_rxLen      <= 11'd0;
      r_endPending <= 1'b0;
      r_pendGood   <= 1'b0;
      r_pendLen    <= 11'd0;
    end else begin
      r_rxByte     <= w_nxtByte;
      r_rxValid    <= w_nxtValid;
      r_rxFirst    <= w_nxtFirst;
      r_rxEnd      <= w_nxtEnd;
      r_rxGood     <= w_nxtGood;
      r_rxLen      <= w_nxtLen;
      r_endPending <= w_nxtPending;
      r_pendGood   <= w_nxtPendGood;
      r_pendLen    <= w_nxtPendLen;
    end
  end

  assign rx_byte  = r_rxByte;
  assign rx_valid = r_rxValid;
  assign rx_first = r_rxFirst;
  assign rx_end   = r_rxEnd;
  assign rx_good  = r_rxGood;
  assign rx_len   = r_rxLen;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Testbench for rmii_rx_deframer: frames are built from byte payloads with a
// software CRC-32, expected byte/end events (with cycle timing) are derived
// from how each frame was constructed, and observed events are compared.
module tb_rmii_rx_deframer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;

  logic        mii_clk = 1'b0;
  logic        mii_rst_n = 1'b0;
  logic [3:0]  rmii_D = 4'h0;
  logic [1:0]  rmii_DV = 2'b00;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_first;
  logic        rx_end;
  logic        rx_good;
  logic [10:0] rx_len;

  rmii_rx_deframer #(
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .mii_clk   (mii_clk),
    .mii_rst_n (mii_rst_n),
    .rmii_D    (rmii_D),
    .rmii_DV   (rmii_DV),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_first  (rx_first),
    .rx_end    (rx_end),
    .rx_good   (rx_good),
    .rx_len    (rx_len)
  );

  // 25 MHz clock.
  always #20 mii_clk = ~mii_clk;

  int cycleNo = 0;

  // Count active edges so events can be timestamped.
  always @(posedge mii_clk) cycleNo <= cycleNo + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  b;
    logic        first;
  } byteEv_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        good;
    logic [10:0] len;
  } endEv_t;

  byteEv_t    gotBytes[$];
  byteEv_t    expBytes[$];
  endEv_t     gotEnds[$];
  endEv_t     expEnds[$];
  logic [2:0] stim[$];
  logic [7:0] pl[$];
  int         compared = 0;
  int         mismatched = 0;
  int         startCycle = 0;

  // Record every output event, sampled on the inactive edge.
  always @(negedge mii_clk) begin
    if (rx_valid) gotBytes.push_back('{cyc: 32'(cycleNo), b: rx_byte, first: rx_first});
    if (rx_end)   gotEnds.push_back('{cyc: 32'(cycleNo), good: rx_good, len: rx_len});
  end

  // Standard Ethernet FCS over the first n bytes of q.
  function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        if ((c[0] ^ q[i][k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
        else                          c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic pushByte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) stim.push_back({1'b1, b[2*i +: 2]});
  endtask

  task automatic makePayload(input int n, input bit ramp);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(ramp ? 8'(i) : 8'($urandom));
  endtask

  // Append one frame to the stimulus and the events it should produce.
  // Cycle fields hold offsets from the start of the stimulus run.
  task automatic buildFrame(input int lead, input int flipBit, input int keepBytes,
                            input int extra, input bit terminated);
    logic [7:0]  frame[$];
    logic [31:0] fcs;
    logic [31:0] rxFcs;
    int          sfdIdx;
    int          n;
    int          e;
    int          endOff;
    bit          good;
    frame = pl;
    fcs = crc32(pl, pl.size());
    for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
    if (flipBit >= 0) frame[flipBit/8] = frame[flipBit/8] ^ (8'd1 << (flipBit % 8));
    if (keepBytes >= 0) while (frame.size() > keepBytes) void'(frame.pop_back());
    for (int i = 0; i < lead; i++) stim.push_back(3'b000);
    for (int i = 0; i < 7; i++) pushByte(8'h55);
    pushByte(8'hD5);
    sfdIdx = stim.size() - 1;
    foreach (frame[i]) pushByte(frame[i]);
    for (int i = 0; i < extra; i++) stim.push_back({1'b1, 2'($urandom)});
    n = frame.size();
    for (int k = 0; k < n; k++) begin
      expBytes.push_back('{cyc: 32'((sfdIdx + 4*k + 4)/2 + 1), b: frame[k], first: (k == 0)});
    end
    if (terminated) begin
      e = stim.size();
      stim.push_back(3'b000);
      endOff = e/2 + 1 + (((e % 2) == 1 && extra == 0 && n > 0) ? 1 : 0);
      good = (extra == 0) && (n >= MIN_LEN) && (n <= MAX_LEN) && (n < 2048);
      if (n >= 4) begin
        rxFcs = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
        if (crc32(frame, n - 4) != rxFcs) good = 1'b0;
      end else begin
        good = 1'b0;
      end
      expEnds.push_back('{cyc: 32'(endOff), good: good, len: (n > 2047) ? 11'd2047 : 11'(n)});
    end
  endtask

  // Play the stimulus two dibits per clock; optionally hit reset right after.
  task automatic applyStimulus(input bit resetAfter, input int trailIdle);
    int pairs;
    @(negedge mii_clk);
    startCycle = cycleNo;
    if ((stim.size() % 2) == 1) stim.push_back(3'b000);
    pairs = stim.size() / 2;
    for (int j = 0; j < pairs; j++) begin
      rmii_D  = {stim[2*j+1][1:0], stim[2*j][1:0]};
      rmii_DV = {stim[2*j+1][2], stim[2*j][2]};
      @(negedge mii_clk);
    end
    if (resetAfter) begin
      #5 mii_rst_n = 1'b0;
      #1;
      compared++;
      assert ({rx_byte, rx_valid, rx_first, rx_end, rx_good, rx_len} === 23'd0) else begin
        mismatched++;
        $error("[TB] FAIL resetMidFrame outputs got=%06h exp=000000",
               {rx_byte, rx_valid, rx_first, rx_end, rx_good, rx_len});
      end
      rmii_D  = 4'h0;
      rmii_DV = 2'b00;
      repeat (2) @(negedge mii_clk);
      mii_rst_n = 1'b1;
    end
    rmii_D  = 4'h0;
    rmii_DV = 2'b00;
    repeat (trailIdle) @(negedge mii_clk);
    stim.delete();
  endtask

  // Compare observed events against expectations, then clear both.
  task automatic checkOutput(input string tag);
    byteEv_t eb;
    endEv_t  ee;
    compared++;
    assert (gotBytes.size() === expBytes.size()) else begin
      mismatched++;
      $error("[TB] FAIL %s byteCount got=%0d exp=%0d", tag, gotBytes.size(), expBytes.size());
    end
    for (int i = 0; i < gotBytes.size() && i < expBytes.size(); i++) begin
      eb = expBytes[i];
      eb.cyc = eb.cyc + 32'(startCycle);
      compared++;
      assert (gotBytes[i] === eb) else begin
        mismatched++;
        $error("[TB] FAIL %s byte[%0d] got cyc=%0d b=%02h first=%0b exp cyc=%0d b=%02h first=%0b",
               tag, i, gotBytes[i].cyc, gotBytes[i].b, gotBytes[i].first, eb.cyc, eb.b, eb.first);
      end
    end
    compared++;
    assert (gotEnds.size() === expEnds.size()) else begin
      mismatched++;
      $error("[TB] FAIL %s endCount got=%0d exp=%0d", tag, gotEnds.size(), expEnds.size());
    end
    for (int i = 0; i < gotEnds.size() && i < expEnds.size(); i++) begin
      ee = expEnds[i];
      ee.cyc = ee.cyc + 32'(startCycle);
      compared++;
      assert (gotEnds[i] === ee) else begin
        mismatched++;
        $error("[TB] FAIL %s end[%0d] got cyc=%0d good=%0b len=%0d exp cyc=%0d good=%0b len=%0d",
               tag, i, gotEnds[i].cyc, gotEnds[i].good, gotEnds[i].len, ee.cyc, ee.good, ee.len);
      end
    end
    gotBytes.delete();
    expBytes.delete();
    gotEnds.delete();
    expEnds.delete();
  endtask

  // Guard against a hung run.
  initial begin
    #4000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  int lens[6] = '{59, 60, 1518, 1519, 61, 0};
  int n;

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge mii_clk);
    compared++;
    assert (rx_valid === 1'b0) else begin mismatched++; $error("[TB] FAIL rst rx_valid got=%b exp=0", rx_valid); end
    compared++;
    assert (rx_first === 1'b0) else begin mismatched++; $error("[TB] FAIL rst rx_first got=%b exp=0", rx_first); end
    compared++;
    assert (rx_end === 1'b0) else begin mismatched++; $error("[TB] FAIL rst rx_end got=%b exp=0", rx_end); end
    compared++;
    assert (rx_good === 1'b0) else begin mismatched++; $error("[TB] FAIL rst rx_good got=%b exp=0", rx_good); end
    compared++;
    assert (rx_byte === 8'h00) else begin mismatched++; $error("[TB] FAIL rst rx_byte got=%02h exp=00", rx_byte); end
    compared++;
    assert (rx_len === 11'd0) else begin mismatched++; $error("[TB] FAIL rst rx_len got=%0d exp=0", rx_len); end
    mii_rst_n = 1'b1;
    repeat (2) @(negedge mii_clk);

    // Good 64-byte frame, SFD tail on the earlier dibit.
    makePayload(60, 1'b1);
    buildFrame(1, -1, -1, 0, 1'b1);
    applyStimulus(1'b0, 4);
    checkOutput("sfdEarly");

    // Same frame, SFD tail on the later dibit.
    buildFrame(0, -1, -1, 0, 1'b1);
    applyStimulus(1'b0, 4);
    checkOutput("sfdLate");

    // One payload bit flipped.
    buildFrame(1, 8*10 + 3, -1, 0, 1'b1);
    applyStimulus(1'b0, 4);
    checkOutput("crcBad");

    // One stray dibit after a byte boundary.
    buildFrame(0, -1, -1, 1, 1'b1);
    applyStimulus(1'b0, 4);
    checkOutput("misaligned");

    // Carrier starting with a non-preamble dibit, then a clean frame.
    stim.push_back(3'b110);
    for (int i = 0; i < 9; i++) stim.push_back({1'b1, 2'($urandom)});
    stim.push_back(3'b000);
    stim.push_back(3'b000);
    makePayload(60, 1'b0);
    buildFrame(0, -1, -1, 0, 1'b1);
    applyStimulus(1'b0, 4);
    checkOutput("dropThenGood");

    // Reset during byte 20, then a clean frame.
    makePayload(80, 1'b0);
    buildFrame(0, -1, 20, 2, 1'b0);
    applyStimulus(1'b1, 2);
    checkOutput("resetMid");
    makePayload(60, 1'b0);
    buildFrame(1, -1, -1, 0, 1'b1);
    applyStimulus(1'b0, 4);
    checkOutput("afterReset");

    // Length boundaries and random frames.
    lens[5] = $urandom_range(62, 300);
    for (int t = 0; t < 6; t++) begin
      n = lens[t];
      makePayload(n, 1'b0);
      buildFrame($urandom_range(0, 1),
                 (t == 4) ? $urandom_range(0, n*8 - 1) : -1,
                 -1,
                 (t == 5) ? $urandom_range(1, 3) : 0,
                 1'b1);
      applyStimulus(1'b0, 4);
      checkOutput($sformatf("rand%0d", t));
    end

    // Oversized frame that saturates the length counter.
    makePayload(2100, 1'b0);
    buildFrame(0, -1, -1, 0, 1'b1);
    applyStimulus(1'b0, 4);
    checkOutput("saturate");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
